// File: rtl/i2s_pkg.sv
// Shared types for the I2S slave transmitter.
// FSM encoding and word-select channel constants.
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    // A left word starts when WS drops from right to left at a BCLK fall.
    function automatic logic is_left_start(logic ws_prev, logic ws_now);
        return (ws_prev == WS_RIGHT) && (ws_now == WS_LEFT);
    endfunction

    function automatic logic is_right_start(logic ws_prev, logic ws_now);
        return (ws_prev == WS_LEFT) && (ws_now == WS_RIGHT);
    endfunction

endpackage

// File: rtl/i2s_tx_slave_if.sv
// Sample-pair push port for the I2S slave transmitter.
// The producer is the master; the transmitter is the slave.
interface i2s_tx_slave_if #(
    parameter int DATA_W = 24
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_left;
    logic [DATA_W-1:0] in_right;

    modport master (
        output in_valid,
        output in_left,
        output in_right,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_left,
        input  in_right,
        output in_ready
    );
endinterface

// File: rtl/i2s_tx_fifo.sv
// Show-ahead synchronous FIFO of stereo pairs.
// Flush clears pointers and level and overrides push/pop.
module i2s_tx_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     din_i,
    output logic [W-1:0]     dout_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/i2s_tx_slave.sv
// I2S slave transmitter: shifts FIFO sample pairs onto SD
// against an externally generated BCLK/WS, oversampled on HCLK.
module i2s_tx_slave
    import i2s_pkg::*;
#(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = 3
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             en,
    input  logic             flush,
    i2s_tx_slave_if.slave    push,
    input  logic             BCLK,
    input  logic             WS,
    output logic             SD,
    output logic [LVL_W-1:0] fifo_level,
    output logic             underrun,
    input  logic             underrun_clr,
    output logic             frame_start
);
    logic bclk_s1_q;
    logic bclk_s2_q;
    logic bclk_h_q;
    logic ws_s1_q;
    logic ws_s2_q;
    logic ws_prev_q;
    logic fall;
    logic left_edge;
    logic right_edge;

    state_e            state_q;
    logic              sd_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] hold_q;
    logic              underrun_q;
    logic              fstart_q;

    logic [2*DATA_W-1:0] fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic                active;

    assign fall       = bclk_h_q && !bclk_s2_q;
    assign left_edge  = fall && is_left_start(ws_prev_q, ws_s2_q);
    assign right_edge = fall && is_right_start(ws_prev_q, ws_s2_q);
    assign active     = (state_q == ST_SYNC) || (state_q == ST_RUN);
    assign fifo_pop   = en && active && left_edge && !fifo_empty;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            bclk_s1_q <= 1'b0;
            bclk_s2_q <= 1'b0;
            bclk_h_q  <= 1'b0;
            ws_s1_q   <= 1'b0;
            ws_s2_q   <= 1'b0;
            ws_prev_q <= 1'b0;
        end else begin
            bclk_s1_q <= BCLK;
            bclk_s2_q <= bclk_s1_q;
            bclk_h_q  <= bclk_s2_q;
            ws_s1_q   <= WS;
            ws_s2_q   <= ws_s1_q;
            if (fall) begin
                ws_prev_q <= ws_s2_q;
            end
        end
    end

    i2s_tx_fifo #(
        .W     (2 * DATA_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk_i   (HCLK),
        .rst_i   (HRESET),
        .flush_i (flush),
        .push_i  (push.in_valid),
        .pop_i   (fifo_pop),
        .din_i   ({push.in_left, push.in_right}),
        .dout_o  (fifo_dout),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign push.in_ready = !fifo_full;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            sd_q       <= 1'b0;
            shreg_q    <= '0;
            hold_q     <= '0;
            underrun_q <= 1'b0;
            fstart_q   <= 1'b0;
        end else begin
            fstart_q <= 1'b0;
            if (underrun_clr) begin
                underrun_q <= 1'b0;
            end
            if (!en) begin
                state_q <= ST_IDLE;
                sd_q    <= 1'b0;
                shreg_q <= '0;
                hold_q  <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        sd_q    <= 1'b0;
                        state_q <= ST_SYNC;
                    end
                    ST_SYNC, ST_RUN: begin
                        // Last bit of the old word goes out before the reload.
                        if (state_q == ST_RUN && fall) begin
                            sd_q <= shreg_q[DATA_W-1];
                        end
                        if (left_edge) begin
                            state_q  <= ST_RUN;
                            fstart_q <= 1'b1;
                            if (fifo_empty) begin
                                shreg_q    <= '0;
                                hold_q     <= '0;
                                underrun_q <= 1'b1;
                            end else begin
                                shreg_q <= fifo_dout[2*DATA_W-1:DATA_W];
                                hold_q  <= fifo_dout[DATA_W-1:0];
                            end
                        end else if (state_q == ST_RUN && right_edge) begin
                            shreg_q <= hold_q;
                        end else if (state_q == ST_RUN && fall) begin
                            shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        sd_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SD          = sd_q;
    assign underrun    = underrun_q;
    assign frame_start = fstart_q;

endmodule
